// File: rtl/shift_reg_piso_if.sv
// shift_reg_piso_if: word-in / serial-out signal bundle for shift_reg_piso.
// master = word producer / serial consumer side, slave = the transmitter.
interface shift_reg_piso_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [0:WIDTH-1] parallel_data_in;
  logic             load_ready;
  logic             serial_data_out;
  logic             serial_valid;
  logic             last_bit;
  logic             busy;

  modport master (
    output load_valid,
    output parallel_data_in,
    input  load_ready,
    input  serial_data_out,
    input  serial_valid,
    input  last_bit,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  parallel_data_in,
    output load_ready,
    output serial_data_out,
    output serial_valid,
    output last_bit,
    output busy
  );
endinterface

// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-in / serial-out transmitter, element 0 first.
// A word taken on the valid/ready handshake is shifted out one bit per clock
// and framed by serial_valid. Optional macro PISO_DOUBLE_BUFFER_EN adds a
// one-word hold register so consecutive words go out with no gap cycle;
// without it every word is followed by at least one IDLE cycle.
module shift_reg_piso #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  shift_reg_piso_if.slave     bus
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [0:WIDTH-1]   shreg_q, shreg_d;
  logic [0:WIDTH-1]   shreg_shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               at_last;
  logic               accept;

`ifdef PISO_DOUBLE_BUFFER_EN
  logic [0:WIDTH-1]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
`endif

  // Shift toward element 0; a zero enters at the far end so the register
  // drains to all-zero and the line idles low once a word is finished.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi < WIDTH - 1) begin : g_mid
        assign shreg_shifted[gi] = shreg_q[gi+1];
      end else begin : g_end
        assign shreg_shifted[gi] = 1'b0;
      end
    end
  endgenerate

  // Everything below is decoded from registered state only (plus reset).
  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

`ifdef PISO_DOUBLE_BUFFER_EN
  assign bus.load_ready = !hold_full_q && !reset;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
`else
  assign bus.load_ready = (state_q == IDLE) && !reset;
  assign bus.busy       = (state_q == SHIFT);
`endif

  assign accept              = bus.load_valid && bus.load_ready;
  assign bus.serial_data_out = shreg_q[0];
  assign bus.serial_valid    = (state_q == SHIFT);
  assign bus.last_bit        = at_last;

  // Next-state logic: load, shift, reload at the last bit, or return to IDLE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_DOUBLE_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.parallel_data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + 1'b1;
`ifdef PISO_DOUBLE_BUFFER_EN
          // A word offered mid-transmission is parked until the last bit.
          if (accept) begin
            hold_d      = bus.parallel_data_in;
            hold_full_d = 1'b1;
          end
`endif
        end else begin
`ifdef PISO_DOUBLE_BUFFER_EN
          if (hold_full_q) begin
            // Parked word goes straight into the shifter: no gap cycle.
            shreg_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (accept) begin
            // Hold empty but a word arrives on the last bit: bypass the hold.
            shreg_d = bus.parallel_data_in;
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
`else
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
`endif
        end
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any word in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PISO_DOUBLE_BUFFER_EN
  // Hold buffer register; emptied by reset so no parked word survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

endmodule

// File: doc/shift_reg_piso.md
# shift_reg_piso

Parallel-in/serial-out transmitter that completes the serial link opposite `shift_reg_siso` and `shift_reg_sipo`. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it onto a one-bit line, one bit per clock, element 0 first. A downstream `shift_reg_sipo` clocked on the same edge therefore reassembles the word in the same `[0:WIDTH-1]` order. The block sits between word-level producers and the serial data line, and frames each word with a `serial_valid` strobe.

## Interface
Parameters:
- `WIDTH`, default 4: word length in bits, minimum 2.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `load_valid`, input, 1: producer presents a word.
- `parallel_data_in`, input, `[0:WIDTH-1]`: word to transmit; bit 0 is sent first.
- `load_ready`, output, 1: block can accept a word this cycle.
- `serial_data_out`, output, 1: serial line, registered.
- `serial_valid`, output, 1: high while `serial_data_out` carries a word bit, registered.
- `last_bit`, output, 1: high during the final bit of a word.
- `busy`, output, 1: a word is in flight or buffered.

## Operation
- State machine with two states:
  - IDLE: `load_ready`=1 (unless `reset` is high), `serial_valid`=0, `serial_data_out`=0.
  - SHIFT: a word is being transmitted.
- Accept rule: a word is accepted at a rising edge where `load_valid`=1 and `load_ready`=1. Input is sampled only at that edge.
- On accept from IDLE:
  - shift register ← `parallel_data_in`.
  - bit counter ← 0.
  - state → SHIFT.
- SHIFT, counter < WIDTH-1: each edge shifts toward element 0 (element i ← element i+1) and increments the counter.
- SHIFT, counter = WIDTH-1: this is the last bit, and `last_bit`=1. At the next edge:
  - if a next word is available (see Configuration), reload the shift register, set the counter to 0 and stay in SHIFT;
  - otherwise go to IDLE.
- `serial_data_out` is element 0 of the shift register while in SHIFT, and 0 otherwise.
- `busy` = (state==SHIFT) OR (hold buffer full).
- Counter width is `$clog2(WIDTH)`. The counter never exceeds WIDTH-1 and wraps only via the reload path.
- `load_valid` while `load_ready`=0 is ignored. The producer must hold the word until it is accepted.

## Timing
- Reset values: state IDLE, shift register all 0, counter 0, hold buffer empty, `serial_data_out`=0, `serial_valid`=0, `last_bit`=0, `busy`=0.
- `load_ready` is forced to 0 while `reset`=1, and reads 1 in the first cycle after deassertion.
- Latency: a word accepted at edge E drives bit 0 on `serial_data_out` during cycle E→E+1. Bit k appears during cycle E+k→E+k+1.
- Each word occupies exactly WIDTH cycles of `serial_valid`=1.
- Reset asserted mid-word: the word is aborted immediately (asynchronously). Outputs go to their reset values and no residual bits are sent after release.
- Outputs change only on rising edges of `clk` or on assertion of `reset`. `load_ready` and `last_bit` are decoded from registered state only, with no combinational path from `load_valid`.

## Configuration
- Macro `PISO_DOUBLE_BUFFER_EN`.
- Defined:
  - a WIDTH-bit hold register with a full flag is added, and `load_ready` = NOT hold_full.
  - An accept in SHIFT goes to the hold register.
  - An accept at the last-bit edge with hold empty loads the shift register directly.
  - At the last-bit edge with hold full, the shift register ← hold and hold_full ← 0.
  - Result: back-to-back words with zero gap cycles, so `serial_valid` stays continuously high.
- Undefined:
  - there is no hold register, and `load_ready` = (state==IDLE).
  - Every word ends in at least one IDLE cycle, giving a minimum word period of WIDTH+1 cycles.

## Test plan
- Reset release, `load_valid`=0 for 10 cycles -> `serial_data_out`=0, `serial_valid`=0, `busy`=0, `load_ready`=1 throughout.
- WIDTH=4, load `parallel_data_in`[0:3]=1,0,0,0 -> serial 1,0,0,0 on the four cycles after accept. `serial_valid`=1 for exactly 4 cycles, and `last_bit`=1 on the 4th. A looped-back `shift_reg_sipo` then shows `parallel_data_out`=1,0,0,0.
- Load 1,0,1,1, then assert `reset` after the second bit -> outputs are 0 immediately, no further bits are sent, and `load_ready`=1 one cycle after release.
- Macro undefined, `load_valid` held high with words 1,1,0,1 then 0,1,1,0 -> the second word is accepted only in IDLE. There is exactly one `serial_valid`=0 cycle between the words, and the word period is 5 cycles.
- Macro defined, same stimulus -> the second word is accepted during the first word's shifting. The serial stream is 1,1,0,1,0,1,1,0 with `serial_valid` high for 8 consecutive cycles, and `load_ready`=0 only while the hold register is full.
- Macro defined, third word offered while hold is full -> `load_ready`=0, the word is not accepted, and it is sent only after being re-offered; no word is lost or duplicated.
